// File: rtl/pc_reg_if.sv
// Fetch-side bundle for the program-counter register: the load request from
// the NPC mux / hazard unit and the PC views consumed by IF and exception logic.
interface pc_reg_if;
   logic        en;
   logic [31:0] NPC;
   logic [31:0] PC;
   logic [31:0] PC4;
   logic        align_err;
   logic        range_err;

   // Driver of the next-PC request (hazard unit / NPC mux side)
   modport master (
      output en,
      output NPC,
      input  PC,
      input  PC4,
      input  align_err,
      input  range_err
   );

   // The PC register itself
   modport slave (
      input  en,
      input  NPC,
      output PC,
      output PC4,
      output align_err,
      output range_err
   );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register at the head of the IF stage. Loads NPC each cycle
// unless fetch is stalled, and exposes PC+4 plus combinational fetch-fault
// flags (misaligned PC, PC outside instruction memory).
module pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] IM_BASE  = 32'h0000_0000,
   parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
   input  logic     clk,
   input  logic     rst,
   pc_reg_if.slave  bus
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [32:0] pc_offset;

   // Next PC: take NPC verbatim when enabled, otherwise hold (stall)
   always_comb begin
      pc_d = pc_q;
      if (bus.en) begin
         pc_d = bus.NPC;
      end
   end

   // PC register with synchronous active-low reset that overrides en/NPC
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Offset of PC from the memory base in 33 bits: bit 32 set means PC < IM_BASE,
   // and IM_BASE + IM_BYTES never has to be formed, so it cannot overflow
   assign pc_offset     = {1'b0, pc_q} - {1'b0, IM_BASE};

   assign bus.PC        = pc_q;
   assign bus.PC4       = pc_q + 32'd4;
   assign bus.align_err = |pc_q[1:0];
   assign bus.range_err = pc_offset[32] || (pc_offset[31:0] >= IM_BYTES);

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: the driver pushes hand-computed expectations
// into scoreboard queues, and independent monitors pop and compare them.
module tb_pc_reg;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        align_err;
      logic        range_err;
   } expect_t;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   expect_t edge_q[$];
   expect_t probe_q[$];
   event    probe_ev;

   pc_reg_if bus ();

   pc_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single field comparison shared by both monitors
   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
      end
   endtask

   task automatic compareEntry(input expect_t e);
      checkOutput(e.name, "PC",        bus.PC,                  e.pc);
      checkOutput(e.name, "PC4",       bus.PC4,                 e.pc4);
      checkOutput(e.name, "align_err", {31'd0, bus.align_err},  {31'd0, e.align_err});
      checkOutput(e.name, "range_err", {31'd0, bus.range_err},  {31'd0, e.range_err});
   endtask

   // Edge monitor: one expectation retires just after each rising edge
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (edge_q.size() != 0) begin
            e = edge_q.pop_front();
            compareEntry(e);
         end
      end
   end

   // Mid-cycle monitor: checks outputs between edges when the driver asks
   initial begin
      expect_t e;
      forever begin
         @(probe_ev);
         #1;
         if (probe_q.size() != 0) begin
            e = probe_q.pop_front();
            compareEntry(e);
         end
      end
   end

   // Drive one cycle of inputs at the falling edge and queue the state
   // expected right after the following rising edge
   task automatic applyStimulus(input string name, input logic r, input logic e,
                                input logic [31:0] npc, input logic [31:0] exp_pc,
                                input logic [31:0] exp_pc4, input logic exp_align,
                                input logic exp_range);
      expect_t x;
      @(negedge clk);
      rst     = r;
      bus.en  = e;
      bus.NPC = npc;
      x.name = name; x.pc = exp_pc; x.pc4 = exp_pc4;
      x.align_err = exp_align; x.range_err = exp_range;
      edge_q.push_back(x);
      @(posedge clk);
   endtask

   // Assert reset mid-cycle, confirm PC is untouched before the edge,
   // then expect RESET_PC (not NPC) after the edge
   task automatic applyMidReset(input logic [31:0] npc, input logic [31:0] held_pc,
                                input logic [31:0] held_pc4);
      expect_t x;
      @(negedge clk);
      #1;
      rst     = 1'b0;
      bus.en  = 1'b1;
      bus.NPC = npc;
      x.name = "mid_reset_before_edge"; x.pc = held_pc; x.pc4 = held_pc4;
      x.align_err = 1'b0; x.range_err = 1'b0;
      probe_q.push_back(x);
      ->probe_ev;
      x.name = "mid_reset_after_edge"; x.pc = 32'h0; x.pc4 = 32'h4;
      x.align_err = 1'b0; x.range_err = 1'b0;
      edge_q.push_back(x);
      @(posedge clk);
   endtask

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus
   initial begin
      rst     = 1'b0;
      bus.en  = 1'b1;
      bus.NPC = 32'h1234;

      //            name          rst   en    NPC           PC            PC4           al    rg
      applyStimulus("reset_1",    1'b0, 1'b1, 32'h1234,     32'h0,        32'h4,        1'b0, 1'b0);
      applyStimulus("reset_2",    1'b0, 1'b1, 32'h1234,     32'h0,        32'h4,        1'b0, 1'b0);
      applyStimulus("load_12",    1'b1, 1'b1, 32'd12,       32'd12,       32'd16,       1'b0, 1'b0);
      applyStimulus("load_16",    1'b1, 1'b1, 32'd16,       32'd16,       32'd20,       1'b0, 1'b0);
      applyStimulus("stall_1",    1'b1, 1'b0, 32'h40,       32'd16,       32'd20,       1'b0, 1'b0);
      applyStimulus("stall_2",    1'b1, 1'b0, 32'h40,       32'd16,       32'd20,       1'b0, 1'b0);
      applyStimulus("stall_3",    1'b1, 1'b0, 32'h40,       32'd16,       32'd20,       1'b0, 1'b0);
      applyStimulus("unstall",    1'b1, 1'b1, 32'h40,       32'h40,       32'h44,       1'b0, 1'b0);
      applyMidReset(32'h80, 32'h40, 32'h44);
      applyStimulus("release",    1'b1, 1'b1, 32'h80,       32'h80,       32'h84,       1'b0, 1'b0);
      applyStimulus("misalign_6", 1'b1, 1'b1, 32'h6,        32'h6,        32'hA,        1'b1, 1'b0);
      applyStimulus("last_word",  1'b1, 1'b1, 32'hFFC,      32'hFFC,      32'h1000,     1'b0, 1'b0);
      applyStimulus("im_end",     1'b1, 1'b1, 32'h1000,     32'h1000,     32'h1004,     1'b0, 1'b1);
      applyStimulus("wrap",       1'b1, 1'b1, 32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        1'b0, 1'b1);
      applyStimulus("all_ones",   1'b1, 1'b1, 32'hFFFF_FFFF,32'hFFFF_FFFF,32'h3,        1'b1, 1'b1);
      applyStimulus("misalign_3", 1'b1, 1'b1, 32'h3,        32'h3,        32'h7,        1'b1, 1'b0);
      applyStimulus("hold_3",     1'b1, 1'b0, 32'h8,        32'h3,        32'h7,        1'b1, 1'b0);
      applyStimulus("rst_no_en",  1'b0, 1'b0, 32'h8,        32'h0,        32'h4,        1'b0, 1'b0);
      applyStimulus("after_rst",  1'b1, 1'b1, 32'h800,      32'h800,      32'h804,      1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (edge_q.size() != 0 || probe_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain pending=%0d expected=0", edge_q.size() + probe_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
